seq_signed_multiplier: RTL

Sequential two's-complement multiplier built around a radix-2 Booth recoder and a 5-bit iteration counter. It is the multiply-side companion to the signed divider datapath. It accepts one operand pair per `start` pulse, runs one Booth step per clock, and returns a full-width signed product with a single-cycle `done` strobe. It sits beside the signed divider under the same control sequencer.

---
 rtl/seq_signed_multiplier.sv | 122 ++++++++++++
 1 files changed

// File: rtl/seq_signed_multiplier.sv
// Sequential radix-2 Booth signed multiplier: one Booth step per clock, WIDTH cycles per product.
// Optional feature: define MULT_ZERO_SKIP_EN to finish zero-operand requests one cycle after acceptance.
module seq_signed_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [4:0] LAST_STEP = 5'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [WIDTH:0]       m_q, m_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 qm1_q, qm1_d;
    logic [4:0]           cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH:0]       booth_sum;
    logic                 zero_op;

`ifdef MULT_ZERO_SKIP_EN
    assign zero_op = (multiplicand == '0) || (multiplier == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        a_d       = a_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;
        booth_sum = a_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = {multiplicand[WIDTH-1], multiplicand};
                    a_d     = '0;
                    q_d     = multiplier;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                    // Zeroed M and Q with the counter parked on the last step
                    // make the single RUN cycle produce an all-zero product.
                    if (zero_op) begin
                        m_d   = '0;
                        q_d   = '0;
                        cnt_d = LAST_STEP;
                    end
                end
            end
            RUN: begin
                case ({q_q[0], qm1_q})
                    2'b01:   booth_sum = a_q + m_q;
                    2'b10:   booth_sum = a_q - m_q;
                    default: booth_sum = a_q;
                endcase
                a_d   = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == LAST_STEP) begin
                    product_d = {a_d[WIDTH-1:0], q_d};
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            m_q       <= '0;
            a_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            a_q       <= a_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
